// File: rtl/piece_generator.sv
// ---------------------------------------------------------------------------
// piece_generator
//   Spawns, rotates and moves a four-tile falling piece on a BOARD_W x BOARD_H
//   board. Candidate moves and rotations are bounds-checked in a dedicated
//   CHECK cycle. The result is committed only if every tile stays on the board.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   spawn_req                start a new piece at (SPAWN_X, 0), rotation 0
//   rot_req, rot_dir         rotate request; rot_dir 0 = clockwise, 1 = ccw
//   anchor_ld, anchor_x/y    request to move the anchor to (anchor_x, anchor_y)
//   shape_sel                shape code used when RANDOM == 0 (7 acts as 0)
//   t0..t3_x / t0..t3_y      registered tile coordinates
//   shape_id, rot_state      current shape and rotation
//   next_shape               preview of the shape used by the next spawn
//   valid, busy              piece live / bounds check in progress
//   spawn_done, move_ok,     one-cycle status pulses
//   move_fail
// ---------------------------------------------------------------------------
module piece_generator #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int X_W     = 4,
    parameter int Y_W     = 5,
    parameter int SPAWN_X = 4,
    parameter int RANDOM  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           spawn_req,
    input  logic           rot_req,
    input  logic           rot_dir,
    input  logic           anchor_ld,
    input  logic [X_W-1:0] anchor_x,
    input  logic [Y_W-1:0] anchor_y,
    input  logic [2:0]     shape_sel,
    output logic [X_W-1:0] t0_x,
    output logic [X_W-1:0] t1_x,
    output logic [X_W-1:0] t2_x,
    output logic [X_W-1:0] t3_x,
    output logic [Y_W-1:0] t0_y,
    output logic [Y_W-1:0] t1_y,
    output logic [Y_W-1:0] t2_y,
    output logic [Y_W-1:0] t3_y,
    output logic [2:0]     shape_id,
    output logic [1:0]     rot_state,
    output logic [2:0]     next_shape,
    output logic           valid,
    output logic           busy,
    output logic           spawn_done,
    output logic           move_ok,
    output logic           move_fail
);

    localparam int SX_W = X_W + 2;
    localparam int SY_W = Y_W + 2;
    localparam logic signed [SX_W-1:0] BW = SX_W'(BOARD_W);
    localparam logic signed [SY_W-1:0] BH = SY_W'(BOARD_H);

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, CHECK} state_t;

    state_t         state, state_next;
    logic           do_spawn, do_rot, do_move;

    logic [7:0]     lfsr;
    logic [X_W-1:0] anc_x, cand_x;
    logic [Y_W-1:0] anc_y, cand_y;
    logic [1:0]     cand_rot;
    logic [X_W-1:0] tile_x [4];
    logic [Y_W-1:0] tile_y [4];

    // Tiles of the candidate (shape_id, cand_rot, cand_x, cand_y).
    logic [X_W-1:0] cand_tx [4];
    logic [Y_W-1:0] cand_ty [4];
    logic           cand_ok;

    logic [2:0]     sel_shape, lfsr_shape, spawn_shape;

    assign sel_shape   = (shape_sel == 3'd7) ? 3'd0 : shape_sel;
    assign lfsr_shape  = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
    assign spawn_shape = (RANDOM != 0) ? next_shape : sel_shape;

    // Rotation-0 offsets, one byte per tile ({dx, dy} as signed nibbles),
    // tile 0 in the low byte.
    function automatic logic [31:0] base_offsets(input logic [2:0] shp);
        case (shp)
            3'd1:    base_offsets = 32'h13_12_11_10; // I
            3'd2:    base_offsets = 32'h11_20_10_00; // T
            3'd3:    base_offsets = 32'h12_02_01_00; // L
            3'd4:    base_offsets = 32'h12_02_11_10; // J
            3'd5:    base_offsets = 32'h01_F1_10_00; // S (dx = -1 in tile 2)
            3'd6:    base_offsets = 32'h21_11_10_00; // Z
            default: base_offsets = 32'h11_01_10_00; // O
        endcase
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register + next-state / request decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case statement can infer a latch.
        state_next = state;
        do_spawn   = 1'b0;
        do_rot     = 1'b0;
        do_move    = 1'b0;
        case (state)
            IDLE: begin
                if (spawn_req) begin
                    do_spawn   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD:   state_next = ACTIVE;
            ACTIVE: begin
                if (spawn_req) begin
                    do_spawn   = 1'b1;
                    state_next = LOAD;
                end else if (anchor_ld) begin
                    do_move    = 1'b1;
                    state_next = CHECK;
                end else if (rot_req) begin
                    do_rot     = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK:   state_next = ACTIVE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Candidate tile computation and bounds check
    // ------------------------------------------------------------------
    logic [31:0]            offs;
    logic [1:0]             eff_rot;
    logic signed [3:0]      dx, dy, tmp;
    logic signed [SX_W-1:0] sx;
    logic signed [SY_W-1:0] sy;

    always_comb begin
        offs    = base_offsets(shape_id);
        eff_rot = (shape_id == 3'd0) ? 2'd0 : cand_rot; // O never rotates
        cand_ok = 1'b1;
        dx      = '0;
        dy      = '0;
        tmp     = '0;
        sx      = '0;
        sy      = '0;
        for (int i = 0; i < 4; i++) begin
            dx = offs[i*8+4 +: 4];
            dy = offs[i*8   +: 4];
            // Clockwise quarter turn (dx,dy) -> (-dy,dx), applied eff_rot times.
            for (int k = 0; k < 3; k++) begin
                if (2'(k) < eff_rot) begin
                    tmp = dx;
                    dx  = -dy;
                    dy  = tmp;
                end
            end
            sx = $signed({2'b00, cand_x}) + SX_W'(dx);
            sy = $signed({2'b00, cand_y}) + SY_W'(dy);
            cand_tx[i] = sx[X_W-1:0];
            cand_ty[i] = sy[Y_W-1:0];
            if (sx[SX_W-1] || sx >= BW || sy[SY_W-1] || sy >= BH)
                cand_ok = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge values of the others.
        if (rst) begin
            lfsr       <= 8'hA5;
            shape_id   <= '0;
            rot_state  <= '0;
            next_shape <= '0;
            anc_x      <= '0;
            anc_y      <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            cand_rot   <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            spawn_done <= 1'b0;
            move_ok    <= 1'b0;
            move_fail  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tile_x[i] <= '0;
                tile_y[i] <= '0;
            end
        end else begin
            // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            spawn_done <= 1'b0;
            move_ok    <= 1'b0;
            move_fail  <= 1'b0;

            if (RANDOM != 0) begin
                if (do_spawn) next_shape <= lfsr_shape;
            end else begin
                next_shape <= sel_shape;
            end

            // The spawn position is also loaded as the candidate so LOAD can
            // reuse the same tile calculator as CHECK.
            if (do_spawn) begin
                shape_id  <= spawn_shape;
                rot_state <= 2'd0;
                anc_x     <= X_W'(SPAWN_X);
                anc_y     <= '0;
                cand_rot  <= 2'd0;
                cand_x    <= X_W'(SPAWN_X);
                cand_y    <= '0;
            end

            if (do_rot) begin
                cand_rot <= rot_dir ? rot_state - 2'd1 : rot_state + 2'd1;
                cand_x   <= anc_x;
                cand_y   <= anc_y;
                busy     <= 1'b1;
            end

            if (do_move) begin
                cand_rot <= rot_state;
                cand_x   <= anchor_x;
                cand_y   <= anchor_y;
                busy     <= 1'b1;
            end

            if (state == LOAD) begin
                for (int i = 0; i < 4; i++) begin
                    tile_x[i] <= cand_tx[i];
                    tile_y[i] <= cand_ty[i];
                end
                valid      <= 1'b1;
                spawn_done <= 1'b1;
            end

            if (state == CHECK) begin
                busy <= 1'b0;
                if (cand_ok) begin
                    for (int i = 0; i < 4; i++) begin
                        tile_x[i] <= cand_tx[i];
                        tile_y[i] <= cand_ty[i];
                    end
                    rot_state <= cand_rot;
                    anc_x     <= cand_x;
                    anc_y     <= cand_y;
                    move_ok   <= 1'b1;
                end else begin
                    move_fail <= 1'b1;
                end
            end
        end
    end

    assign t0_x = tile_x[0];
    assign t1_x = tile_x[1];
    assign t2_x = tile_x[2];
    assign t3_x = tile_x[3];
    assign t0_y = tile_y[0];
    assign t1_y = tile_y[1];
    assign t2_y = tile_y[2];
    assign t3_y = tile_y[3];

endmodule

// File: doc/piece_generator.md
PIECE_GENERATOR -- requirements
Module: piece_generator

Interface
REQ-001 SHALL have parameter BOARD_W, default 10: board columns; legal x is 0..BOARD_W-1.
REQ-002 SHALL have parameter BOARD_H, default 20: board rows; legal y is 0..BOARD_H-1.
REQ-003 SHALL have parameter X_W, default 4: x coordinate width.
REQ-004 SHALL have parameter Y_W, default 5: y coordinate width.
REQ-005 SHALL have parameter SPAWN_X, default 4: anchor x at spawn (spawn anchor y is always 0).
REQ-006 SHALL have parameter RANDOM, default 1: 1 selects the internal LFSR shape source; 0 selects shape_sel.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port spawn_req, input, 1 bit: start a new piece.
REQ-010 SHALL have ports rot_req and rot_dir, inputs, 1 bit each: rotate request; rot_dir 0 = clockwise, 1 = counter-clockwise.
REQ-011 SHALL have ports anchor_ld (input, 1 bit), anchor_x (input, X_W bits) and anchor_y (input, Y_W bits): request to move the anchor.
REQ-012 SHALL have port shape_sel, input, 3 bits: shape code when RANDOM=0 (0 O, 1 I, 2 T, 3 L, 4 J, 5 S, 6 Z; 7 is treated as 0).
REQ-013 SHALL have ports t0_x..t3_x (outputs, X_W bits each) and t0_y..t3_y (outputs, Y_W bits each): registered tile coordinates.
REQ-014 SHALL have ports shape_id (output, 3 bits), rot_state (output, 2 bits) and next_shape (output, 3 bits): current shape, current rotation, preview shape.
REQ-015 SHALL have ports valid, busy, spawn_done, move_ok and move_fail, outputs, 1 bit each: piece live, check in progress, and three one-cycle status pulses.

Function
REQ-016 SHALL use FSM states IDLE, LOAD, ACTIVE and CHECK.
REQ-017 SHALL, in IDLE or ACTIVE when spawn_req is sampled:
- latch shape_id from next_shape (RANDOM=1) or from shape_sel (RANDOM=0);
- set rot_state=0 and anchor=(SPAWN_X,0);
- go to LOAD.
REQ-018 SHALL, in LOAD, register the tiles, set valid=1, pulse spawn_done for one cycle and go to ACTIVE, so tiles are valid two edges after spawn_req; no bounds check is done on spawn.
REQ-019 SHALL compute each tile as anchor plus the rotated offset (dx,dy), using signed arithmetic at least X_W+2 / Y_W+2 bits wide.
REQ-020 SHALL use these rotation-0 offsets:
- O (0,0)(1,0)(0,1)(1,1)
- I (1,0)(1,1)(1,2)(1,3)
- T (0,0)(1,0)(2,0)(1,1)
- L (0,0)(0,1)(0,2)(1,2)
- J (1,0)(1,1)(0,2)(1,2)
- S (0,0)(1,0)(-1,1)(0,1)
- Z (0,0)(1,0)(1,1)(2,1)
REQ-021 SHALL rotate offsets as follows: clockwise maps (dx,dy) to (-dy,dx); rotation r applies that map r times; shape O always uses its rotation-0 offsets.
REQ-022 SHALL, in ACTIVE, give priority spawn_req > anchor_ld > rot_req; lower-priority requests in the same cycle are dropped.
REQ-023 SHALL, in ACTIVE on rot_req, latch candidate rotation rot_state+1 (rot_dir=0) or rot_state-1 (rot_dir=1), both mod 4, keep the current anchor, set busy=1 and go to CHECK.
REQ-024 SHALL, in ACTIVE on anchor_ld, latch candidate anchor (anchor_x, anchor_y), keep the current rotation, set busy=1 and go to CHECK.
REQ-025 SHALL, in CHECK, commit a candidate only if all four tiles have 0<=x<BOARD_W and 0<=y<BOARD_H:
- on commit, update tiles, rot_state and anchor, and pulse move_ok;
- otherwise leave all state unchanged and pulse move_fail;
- in both cases clear busy and return to ACTIVE one edge later.
REQ-026 SHALL ignore all requests while in CHECK or LOAD.
REQ-027 SHALL ignore rot_req and anchor_ld while in IDLE.
REQ-028 SHALL step an 8-bit LFSR (x^8+x^6+x^5+x^4+1) every cycle, with seed 8'hA5.
REQ-029 SHALL, on each spawn with RANDOM=1, load next_shape from lfsr[2:0], mapping 7 to 0; with RANDOM=0, next_shape SHALL continuously mirror shape_sel (7 mapped to 0).

Reset
REQ-030 SHALL, on rst assertion in any state including mid-CHECK, asynchronously enter IDLE, with:
- all tile outputs, shape_id, rot_state, next_shape and anchor = 0;
- valid, busy and all pulses = 0;
- LFSR = 8'hA5.
REQ-031 SHALL honour no request on the first edge after rst deasserts unless that request is sampled high on that edge.

Verification
REQ-032 Reset check: rst high -> valid=0, busy=0, all tiles 0, next_shape=0.
REQ-033 Spawn T: RANDOM=0, shape_sel=2, spawn_req for one cycle -> two edges later valid=1, tiles (4,0)(5,0)(6,0)(5,1), rot_state=0, spawn_done for one cycle.
REQ-034 Rotate I: I spawned, rot_req with rot_dir=0 -> move_ok, tiles (4,1)(3,1)(2,1)(1,1), rot_state=1; then from rotation 0, rot_dir=1 -> move_fail, tiles unchanged.
REQ-035 Move out of bounds: T at rotation 0, anchor_ld to (9,5) -> move_fail, anchor and tiles unchanged; anchor_ld to (7,5) -> move_ok, tiles (7,5)(8,5)(9,5)(8,6).
REQ-036 Priority and busy: spawn_req and rot_req together in ACTIVE -> respawn only, rot_state=0, no move pulse; rot_req during CHECK -> ignored.
REQ-037 Reset mid-operation: rst asserted during CHECK -> immediate IDLE with all outputs 0; a later spawn works normally.
